// File: rtl/contrast_stretch.sv
// Streaming contrast stretch: out = clamp(((in - MID) * gain) >>> FRAC_W + MID), two-stage
// elastic valid/ready pipeline with a per-frame count of clamped pixels.
module contrast_stretch #(
  parameter int DATA_W = 8,
  parameter int GAIN_W = 8,
  parameter int FRAC_W = 4,
  parameter int MID    = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  input  logic              s_eof,
  input  logic [GAIN_W-1:0] gain,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eof,
  output logic [CNT_W-1:0]  sat_count,
  output logic              sat_upd
);

  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam int SC_W   = PROD_W + 1;
  localparam int MAXV   = (1 << DATA_W) - 1;

  // stage 1 registers
  logic                     r_v1;
  logic signed [PROD_W-1:0] r_prod1;
  logic                     r_sof1;
  logic                     r_eof1;
  // stage 2 registers (drive the output port)
  logic                     r_v2;
  logic [DATA_W-1:0]        r_data2;
  logic                     r_sof2;
  logic                     r_eof2;
  logic                     r_sat2;
  // frame state
  logic [GAIN_W-1:0]        r_gain_q;
  logic [CNT_W-1:0]         r_acc;
  logic [CNT_W-1:0]         r_sat_count;
  logic                     r_sat_upd;

  logic                     w_rdy1;
  logic                     w_rdy2;
  logic                     w_in_xfer;
  logic                     w_out_xfer;
  logic [GAIN_W-1:0]        w_eff_gain;
  logic signed [DATA_W:0]   w_diff;
  logic signed [PROD_W-1:0] w_diff_x;
  logic signed [PROD_W-1:0] w_gain_x;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_shr;
  logic signed [SC_W-1:0]   w_sc;
  logic                     w_lo;
  logic                     w_hi;
  logic [DATA_W-1:0]        w_clamp;
  logic [CNT_W-1:0]         w_base;
  logic [CNT_W-1:0]         w_nacc;

  assign w_rdy2     = !r_v2 || m_ready;
  assign w_rdy1     = !r_v1 || w_rdy2;
  assign s_ready    = w_rdy1;
  assign w_in_xfer  = s_valid && w_rdy1;
  assign w_out_xfer = r_v2 && m_ready;

  // A sof beat uses its own gain so the whole frame sees one value.
  assign w_eff_gain = s_sof ? gain : r_gain_q;

  assign w_diff   = $signed({1'b0, s_data}) - $signed((DATA_W+1)'(MID));
  assign w_diff_x = {{(PROD_W-DATA_W-1){w_diff[DATA_W]}}, w_diff};
  assign w_gain_x = {{(PROD_W-GAIN_W){1'b0}}, w_eff_gain};
  assign w_prod   = w_diff_x * w_gain_x;

  assign w_shr   = r_prod1 >>> FRAC_W;
  assign w_sc    = {w_shr[PROD_W-1], w_shr} + $signed(SC_W'(MID));
  assign w_lo    = w_sc < 0;
  assign w_hi    = w_sc > $signed(SC_W'(MAXV));
  assign w_clamp = w_lo ? '0 : (w_hi ? '1 : w_sc[DATA_W-1:0]);

  // Frame accumulator restarts on sof and saturates rather than wrapping.
  assign w_base = r_sof2 ? '0 : r_acc;
  assign w_nacc = (w_base == '1) ? w_base : w_base + CNT_W'(r_sat2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_prod1 <= '0;
      r_sof1  <= 1'b0;
      r_eof1  <= 1'b0;
    end else if (w_rdy1) begin
      r_v1 <= s_valid;
      if (s_valid) begin
        r_prod1 <= w_prod;
        r_sof1  <= s_sof;
        r_eof1  <= s_eof;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_data2 <= '0;
      r_sof2  <= 1'b0;
      r_eof2  <= 1'b0;
      r_sat2  <= 1'b0;
    end else if (w_rdy2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_data2 <= w_clamp;
        r_sof2  <= r_sof1;
        r_eof2  <= r_eof1;
        r_sat2  <= w_lo || w_hi;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gain_q <= GAIN_W'(1 << FRAC_W);
    end else if (w_in_xfer && s_sof) begin
      r_gain_q <= gain;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_sat_count <= '0;
      r_sat_upd   <= 1'b0;
    end else begin
      r_sat_upd <= 1'b0;
      if (w_out_xfer) begin
        if (r_eof2) begin
          r_sat_count <= w_nacc;
          r_sat_upd   <= 1'b1;
          r_acc       <= '0;
        end else begin
          r_acc <= w_nacc;
        end
      end
    end
  end

  assign m_valid   = r_v2;
  assign m_data    = r_data2;
  assign m_sof     = r_sof2;
  assign m_eof     = r_eof2;
  assign sat_count = r_sat_count;
  assign sat_upd   = r_sat_upd;

endmodule

// File: tb/tb_contrast_stretch.sv
// Randomized bench for contrast_stretch against an arithmetic reference model
// of the stretch, the frame-coherent gain and the per-frame clamp count.
module tb_contrast_stretch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        s_sof = 1'b0;
  logic        s_eof = 1'b0;
  logic [7:0]  gain = 8'h10;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic        m_sof;
  logic        m_eof;
  logic [15:0] sat_count;
  logic        sat_upd;

  contrast_stretch dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .s_eof(s_eof), .gain(gain),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eof(m_eof),
    .sat_count(sat_count), .sat_upd(sat_upd)
  );

  always #5 clk = ~clk;

  typedef struct { int pix; bit sof; bit eof; int g; } beat_t;
  typedef struct { int data; bit sof; bit eof; } out_t;

  beat_t stim_q[$];
  out_t  exp_q[$];
  int    cnt_q[$];
  int    n_chk = 0;
  int    n_pass = 0;

  // reference model state
  int    m_gain = 16;
  int    m_acc = 0;
  // bench bookkeeping
  beat_t cur;
  bit    pend = 0;
  bit    held = 0;
  bit    exp_upd = 0;
  int    exp_cnt = 0;
  int    held_data = 0;
  bit    held_sof = 0;
  bit    held_eof = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int floor_div16(input int p);
    int q;
    q = p / 16;
    if (p < 0 && (p % 16) != 0) q = q - 1;
    return q;
  endfunction

  task automatic model_accept(input beat_t b);
    int g, sc;
    bit sat;
    out_t o;
    g = b.sof ? b.g : m_gain;
    if (b.sof) m_gain = b.g;
    sc = floor_div16((b.pix - 128) * g) + 128;
    sat = (sc < 0) || (sc > 255);
    o.data = (sc < 0) ? 0 : ((sc > 255) ? 255 : sc);
    o.sof = b.sof;
    o.eof = b.eof;
    exp_q.push_back(o);
    m_acc = b.sof ? int'(sat) : m_acc + int'(sat);
    if (m_acc > 65535) m_acc = 65535;
    if (b.eof) begin
      cnt_q.push_back(m_acc);
      m_acc = 0;
    end
  endtask

  task automatic add_px(input int pix, input bit sof, input bit eof, input int g);
    beat_t b;
    b.pix = pix; b.sof = sof; b.eof = eof; b.g = g;
    stim_q.push_back(b);
  endtask

  function automatic int rand_pix();
    int r;
    r = $urandom_range(7);
    if (r == 0) return 0;
    if (r == 1) return 255;
    return $urandom_range(255);
  endfunction

  function automatic int rand_gain();
    int r;
    r = $urandom_range(6);
    case (r)
      0: return 8'h10;
      1: return 8'h20;
      2: return 8'h08;
      3: return 8'h30;
      4: return 8'h00;
      5: return 8'hFF;
      default: return $urandom_range(255);
    endcase
  endfunction

  // mode 0: valid/ready always high; 1: random gaps and backpressure;
  // 2: stream with m_ready low on loop cycles 2..4
  task automatic run(input int max_cyc, input int mode, input bit need_done);
    int c = 0;
    out_t o;
    while (c < max_cyc &&
           !(need_done && stim_q.size() == 0 && !pend && exp_q.size() == 0 && !exp_upd)) begin
      @(negedge clk);
      if (!pend) begin
        if (stim_q.size() > 0 && (mode != 1 || $urandom_range(3) != 0)) begin
          cur = stim_q.pop_front();
          pend = 1;
        end
      end
      s_valid = pend;
      if (pend) begin
        s_data = 8'(cur.pix); s_sof = cur.sof; s_eof = cur.eof; gain = 8'(cur.g);
      end else begin
        s_data = 8'($urandom_range(255)); s_sof = 1'($urandom_range(1));
        s_eof = 1'($urandom_range(1)); gain = 8'($urandom_range(255));
      end
      if (mode == 0) m_ready = 1'b1;
      else if (mode == 1) m_ready = 1'($urandom_range(1));
      else m_ready = !(c >= 2 && c <= 4);
      #1;
      chk("sat_upd", sat_upd, exp_upd);
      if (exp_upd) chk("sat_count", sat_count, exp_cnt);
      if (held) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, held_data);
        chk("hold_flags", {m_sof, m_eof}, {held_sof, held_eof});
      end
      if (mode == 2 && c >= 2 && c <= 4) chk("s_ready_full", s_ready, 0);
      if (s_valid && s_ready) begin
        model_accept(cur);
        pend = 0;
      end
      exp_upd = 0;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", m_data, 32'hFFFF_FFFF);
        else begin
          o = exp_q.pop_front();
          chk("m_data", m_data, o.data);
          chk("m_sof_eof", {m_sof, m_eof}, {o.sof, o.eof});
          if (o.eof) begin
            exp_upd = 1;
            exp_cnt = cnt_q.pop_front();
          end
        end
      end
      held = m_valid && !m_ready;
      held_data = m_data; held_sof = m_sof; held_eof = m_eof;
      c++;
    end
    if (need_done && (stim_q.size() != 0 || pend || exp_q.size() != 0))
      chk("timeout_drain", exp_q.size() + stim_q.size() + int'(pend), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    stim_q.delete(); exp_q.delete(); cnt_q.delete();
    m_gain = 16; m_acc = 0;
    pend = 0; held = 0; exp_upd = 0;
    @(negedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_sat_upd", sat_upd, 0);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_m_data", m_data, 0);
    chk("rst_s_ready", s_ready, 1);

    // latency: one-pixel frame, output visible two edges after acceptance
    @(negedge clk);
    s_valid = 1; s_data = 200; s_sof = 1; s_eof = 1; gain = 8'h10; m_ready = 1;
    #1 chk("lat_s_ready", s_ready, 1);
    @(negedge clk);
    s_valid = 0;
    #1 chk("lat_1clk_valid", m_valid, 0);
    @(negedge clk);
    #1 chk("lat_2clk_valid", m_valid, 1);
    chk("lat_2clk_data", m_data, 200);
    @(negedge clk);
    #1 chk("lat_upd", sat_upd, 1);
    chk("lat_cnt", sat_count, 0);
    m_gain = 16;

    // unity gain passthrough
    add_px(0, 1, 0, 16); add_px(128, 0, 0, 16); add_px(200, 0, 0, 16); add_px(255, 0, 1, 16);
    run(100, 0, 1);
    chk("unity_cnt", sat_count, 0);

    // gain 2.0 saturates both ways
    add_px(200, 1, 0, 8'h20); add_px(50, 0, 0, 8'h20); add_px(128, 0, 1, 8'h20);
    run(100, 0, 1);
    chk("g2_cnt", sat_count, 2);

    // gain 0.5, floor rounding of negative product
    add_px(50, 1, 0, 8'h08); add_px(201, 0, 1, 8'h08);
    run(100, 0, 1);

    // mid-frame gain change ignored until next sof
    add_px(60, 1, 0, 8'h10);
    for (int i = 0; i < 4; i++) add_px(rand_pix(), 0, i == 3, 8'h30);
    for (int i = 0; i < 3; i++) add_px(rand_pix(), i == 0, i == 2, 8'h30);
    run(100, 1, 1);

    // backpressure during a 10-beat stream
    for (int i = 0; i < 10; i++) add_px(rand_pix(), i == 0, i == 9, 8'h18);
    run(200, 2, 1);

    // random frames, including one-pixel frames
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(12, 1);
      int g0 = rand_gain();
      for (int i = 0; i < len; i++)
        add_px(rand_pix(), i == 0, i == len - 1, (i == 0) ? g0 : rand_gain());
    end
    run(4000, 1, 1);

    // reset in the middle of a frame, then a frame without sof counts from zero
    for (int i = 0; i < 20; i++) add_px(rand_pix(), i == 0, i == 19, 8'h30);
    run(6, 1, 0);
    do_reset();
    for (int i = 0; i < 5; i++) add_px(rand_pix(), 0, i == 4, 8'h40);
    run(200, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
